i2s_rx_capture: RTL and testbench
=================================

Name: i2s_rx_capture

Overview:
Upstream capture stage for the audio_to_AXI register block. It receives a Philips-I2S serial stream (BCLK, LRCLK, SDATA) asynchronous to ACLK and deserialises each stereo frame into a left/right sample pair. Each pair is presented on a valid/ready interface, which the AXI4-Lite slave latches into its readable registers. An overrun flag is provided for the register map.

Parameters:
SAMPLE_WIDTH, 24, bits captured per channel (8..32); output sample width.
SYNC_STAGES, 2, synchroniser flops on each I2S input (>=2).

Ports:
ACLK  in  1  system clock; must be >= 4x BCLK frequency.
ARESET  in  1  synchronous, active-high reset.
en  in  1  capture enable.
i2s_bclk  in  1  serial bit clock, async.
i2s_lrclk  in  1  word select, async; low = left, high = right.
i2s_sdata  in  1  serial data, MSB first, async.
m_left  out  SAMPLE_WIDTH  left sample of the presented pair.
m_right  out  SAMPLE_WIDTH  right sample of the presented pair.
m_valid  out  1  pair available.
m_ready  in  1  consumer accepts the pair.
overrun  out  1  sticky: a completed pair was dropped.
clear_overrun  in  1  single-cycle clear of overrun.

Behaviour:
- Clock/reset: one clock (ACLK). Reset is synchronous and active-high (ARESET).
- Reset values: m_left=0, m_right=0, m_valid=0, overrun=0. All synchronisers, shift register, bit counter and FSM are cleared; FSM goes to IDLE.
- Input sync: bclk, lrclk and sdata pass through SYNC_STAGES flops, plus one extra bclk flop for edge detection.
- Sampling: a BCLK rising edge is detected when synced bclk=1 and delayed bclk=0. Synced lrclk and sdata are sampled in that same ACLK cycle. All further behaviour is defined per detected edge.
- Boundary: edge e0 is the first edge whose sampled lrclk differs from the lrclk sampled at the previous edge.
- I2S timing: the sdata bit at e0 is the last bit of the outgoing channel and is appended to that channel's word before completion. The MSB of the new channel is sampled at e0+1.
- Capture: a per-channel bit counter counts bits from the MSB. Bits are shifted in while count < SAMPLE_WIDTH. Bits beyond SAMPLE_WIDTH are ignored and the counter saturates.
- Short slot: if count < SAMPLE_WIDTH at completion, the word is left-aligned and zero-padded: word = shreg << (SAMPLE_WIDTH-count).
- FSM states: IDLE, LEFT, RIGHT.
  - IDLE: on reset or en=0. Waits for a boundary where sampled lrclk goes 1->0, then goes to LEFT. No word completes on this boundary.
  - LEFT -> RIGHT on a boundary with lrclk 0->1: completed word goes to an internal left_hold.
  - RIGHT -> LEFT on a boundary with lrclk 1->0: completed word plus left_hold form a new pair.
- Output register update:
  - If m_valid=0, or m_valid=1 and m_ready=1 in the same cycle: m_left/m_right load the new pair and m_valid=1 next cycle.
  - If m_valid=1 and m_ready=0: the new pair is dropped, outputs are unchanged and overrun is set.
  - m_valid&m_ready with no new pair: m_valid=0 next cycle; data is held.
- Latency: m_valid rises exactly SYNC_STAGES+2 ACLK cycles after the first ACLK edge that samples i2s_bclk high at the completing e0 (4 cycles at default).
- Overrun: set has priority over clear_overrun in the same cycle.
- en=0: the FSM goes to IDLE at once and any partial word and left_hold are discarded. A pending m_valid pair stays until accepted. On re-enable, capture restarts at the next left boundary.
- Reset mid-frame: everything is cleared and the partial frame is discarded. Capture resumes at the next left boundary after ARESET falls.

Optional Feature:
Macro I2S_RX_LJ_EN.
- Defined: left-justified format. The sdata bit at e0 is the MSB of the new channel and is not appended to the outgoing word. The outgoing word completes with the bits sampled up to e0-1.
- Undefined: standard I2S one-bit delay as specified above.
- All other behaviour is identical in both modes.

Test Plan:
- Default params, 32-bit slots, left=0x123456, right=0xABCDEF, m_ready=1 -> m_valid pulses once with m_left=0x123456, m_right=0xABCDEF, 4 ACLK after the completing BCLK edge.
- 16-bit slots, left=0xBEEF, right=0x0001 -> m_left=0xBEEF00, m_right=0x000100.
- m_ready=0 across two frames (0x111111/0x222222 then 0x333333/0x444444) -> outputs hold 0x111111/0x222222 and overrun=1. Pulse clear_overrun -> overrun=0. Assert m_ready -> m_valid drops.
- m_ready pulsed in the same cycle a new pair completes -> new pair loaded, m_valid stays 1, overrun stays 0.
- en dropped mid-left-word, then raised -> no pair from the broken frame; the next full frame 0x0A0B0C/0x0D0E0F is delivered correctly. Repeat using ARESET mid-frame with the same result.
- I2S_RX_LJ_EN defined, LJ stream left=0x800001, right=0x7FFFFF -> m_left=0x800001, m_right=0x7FFFFF. The same stream without the macro produces different values.

Source files
------------

// File: rtl/i2s_rx_capture.sv
// I2S receive capture: deserialises async BCLK/LRCLK/SDATA into left/right pairs on valid/ready.
// Define I2S_RX_LJ_EN to receive left-justified framing instead of the I2S one-bit delay.
module i2s_rx_capture #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    en,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] m_left,
    output logic [SAMPLE_WIDTH-1:0] m_right,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    overrun,
    input  logic                    clear_overrun
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    logic [SYNC_STAGES-1:0]  bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0]  lr_sync_q, lr_sync_d;
    logic [SYNC_STAGES-1:0]  sd_sync_q, sd_sync_d;
    logic                    bclk_dly_q, bclk_dly_d;
    logic                    edge_q, edge_d;
    logic                    lr_smp_q, lr_smp_d;
    logic                    sd_smp_q, sd_smp_d;
    logic                    prev_lr_q, prev_lr_d;
    state_t                  state_q, state_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                    pair_vld_q, pair_vld_d;
    logic [SAMPLE_WIDTH-1:0] pair_left_q, pair_left_d;
    logic [SAMPLE_WIDTH-1:0] pair_right_q, pair_right_d;
    logic [SAMPLE_WIDTH-1:0] m_left_q, m_left_d;
    logic [SAMPLE_WIDTH-1:0] m_right_q, m_right_d;
    logic                    m_valid_q, m_valid_d;
    logic                    overrun_q, overrun_d;

    logic                    bclk_s;
    logic                    boundary;
    logic [SAMPLE_WIDTH-1:0] sh_app;
    logic [CW-1:0]           cnt_app;
    logic [SAMPLE_WIDTH-1:0] fin_sh;
    logic [CW-1:0]           fin_cnt;
    logic [SAMPLE_WIDTH-1:0] start_sh;
    logic [CW-1:0]           start_cnt;
    logic [SAMPLE_WIDTH-1:0] word;
    logic                    overrun_set;

    assign bclk_s = bclk_sync_q[SYNC_STAGES-1];

    // Synchronisers and rising-edge sample stage
    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
        sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
        bclk_dly_d  = bclk_s;
        edge_d      = bclk_s & ~bclk_dly_q;
        lr_smp_d    = lr_smp_q;
        sd_smp_d    = sd_smp_q;
        if (edge_d) begin
            lr_smp_d = lr_sync_q[SYNC_STAGES-1];
            sd_smp_d = sd_sync_q[SYNC_STAGES-1];
        end
        prev_lr_d = edge_q ? lr_smp_q : prev_lr_q;
    end

    assign boundary = edge_q & (lr_smp_q ^ prev_lr_q);

    // Word assembly: append current bit while below width, then left-align
    always_comb begin
        sh_app  = shreg_q;
        cnt_app = cnt_q;
        if (cnt_q < CNT_MAX) begin
            sh_app  = {shreg_q[SAMPLE_WIDTH-2:0], sd_smp_q};
            cnt_app = cnt_q + CW'(1);
        end
`ifdef I2S_RX_LJ_EN
        fin_sh    = shreg_q;
        fin_cnt   = cnt_q;
        start_sh  = {{(SAMPLE_WIDTH-1){1'b0}}, sd_smp_q};
        start_cnt = CW'(1);
`else
        fin_sh    = sh_app;
        fin_cnt   = cnt_app;
        start_sh  = '0;
        start_cnt = '0;
`endif
        word = fin_sh << (CNT_MAX - fin_cnt);
    end

    // Frame FSM
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        left_hold_d  = left_hold_q;
        pair_vld_d   = 1'b0;
        pair_left_d  = pair_left_q;
        pair_right_d = pair_right_q;
        if (!en) begin
            state_d     = IDLE;
            shreg_d     = '0;
            cnt_d       = '0;
            left_hold_d = '0;
        end else if (edge_q) begin
            unique case (state_q)
                IDLE: begin
                    if (boundary && !lr_smp_q) begin
                        state_d = LEFT;
                        shreg_d = start_sh;
                        cnt_d   = start_cnt;
                    end
                end
                LEFT: begin
                    if (boundary) begin
                        state_d     = RIGHT;
                        left_hold_d = word;
                        shreg_d     = start_sh;
                        cnt_d       = start_cnt;
                    end else begin
                        shreg_d = sh_app;
                        cnt_d   = cnt_app;
                    end
                end
                RIGHT: begin
                    if (boundary) begin
                        state_d      = LEFT;
                        pair_vld_d   = 1'b1;
                        pair_left_d  = left_hold_q;
                        pair_right_d = word;
                        shreg_d      = start_sh;
                        cnt_d        = start_cnt;
                    end else begin
                        shreg_d = sh_app;
                        cnt_d   = cnt_app;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output register with drop-on-full overrun
    always_comb begin
        m_left_d    = m_left_q;
        m_right_d   = m_right_q;
        m_valid_d   = m_valid_q;
        overrun_set = 1'b0;
        if (pair_vld_q) begin
            if (!m_valid_q || m_ready) begin
                m_left_d  = pair_left_q;
                m_right_d = pair_right_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bclk_sync_q  <= '0;
            lr_sync_q    <= '0;
            sd_sync_q    <= '0;
            bclk_dly_q   <= 1'b0;
            edge_q       <= 1'b0;
            lr_smp_q     <= 1'b0;
            sd_smp_q     <= 1'b0;
            prev_lr_q    <= 1'b0;
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            left_hold_q  <= '0;
            pair_vld_q   <= 1'b0;
            pair_left_q  <= '0;
            pair_right_q <= '0;
            m_left_q     <= '0;
            m_right_q    <= '0;
            m_valid_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lr_sync_q    <= lr_sync_d;
            sd_sync_q    <= sd_sync_d;
            bclk_dly_q   <= bclk_dly_d;
            edge_q       <= edge_d;
            lr_smp_q     <= lr_smp_d;
            sd_smp_q     <= sd_smp_d;
            prev_lr_q    <= prev_lr_d;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            left_hold_q  <= left_hold_d;
            pair_vld_q   <= pair_vld_d;
            pair_left_q  <= pair_left_d;
            pair_right_q <= pair_right_d;
            m_left_q     <= m_left_d;
            m_right_q    <= m_right_d;
            m_valid_q    <= m_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_left  = m_left_q;
    assign m_right = m_right_q;
    assign m_valid = m_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Directed bench for i2s_rx_capture: frames, short slots, overrun, enable/reset recovery.
// Streams follow the DUT framing (left-justified when I2S_RX_LJ_EN is defined).
`timescale 1ns/1ps
module tb_i2s_rx_capture;

    localparam int W = 24;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         en = 1'b0;
    logic         bclk = 1'b0;
    logic         lrclk = 1'b0;
    logic         sdata = 1'b0;
    logic         m_ready = 1'b0;
    logic         clear_overrun = 1'b0;
    logic [W-1:0] m_left;
    logic [W-1:0] m_right;
    logic         m_valid;
    logic         overrun;

    int           tests = 0;
    int           fails = 0;
    int           hs_total = 0;
    logic [W-1:0] hs_left = '0;
    logic [W-1:0] hs_right = '0;
    logic         pend = 1'b0;
    logic         mv_hist [8];

    i2s_rx_capture #(.SAMPLE_WIDTH(W), .SYNC_STAGES(2)) dut (
        .ACLK          (aclk),
        .ARESET        (areset),
        .en            (en),
        .i2s_bclk      (bclk),
        .i2s_lrclk     (lrclk),
        .i2s_sdata     (sdata),
        .m_left        (m_left),
        .m_right       (m_right),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 aclk = ~aclk;

    // Handshake monitor, sampled mid-cycle
    always begin
        @(negedge aclk);
        #2;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            hs_total = hs_total + 1;
            hs_left  = m_left;
            hs_right = m_right;
        end
    end

    // One BCLK period; k counts negedges after the first ACLK edge that sees BCLK high
    task automatic bit_edge(input logic lr, input logic sd, input int rdy_k);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = sd;
        repeat (4) @(negedge aclk);
        bclk = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            mv_hist[k] = m_valid;
            if (rdy_k >= 0 && k == rdy_k) m_ready = 1'b1;
            if (rdy_k >= 0 && k == rdy_k + 1) m_ready = 1'b0;
            if (k == 3) bclk = 1'b0;
        end
    endtask

    task automatic send_word_lj(input logic lr, input logic [31:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) bit_edge(lr, w[i], -1);
        pend = 1'b0;
    endtask

    task automatic send_word(input logic lr, input logic [31:0] w, input int nbits);
`ifdef I2S_RX_LJ_EN
        send_word_lj(lr, w, nbits);
`else
        bit_edge(lr, pend, -1);
        for (int i = nbits - 1; i >= 1; i--) bit_edge(lr, w[i], -1);
        pend = w[0];
`endif
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
        send_word(1'b0, l, nbits);
        send_word(1'b1, r, nbits);
    endtask

    task automatic preamble();
        pend = 1'b0;
        bit_edge(1'b1, 1'b0, -1);
        bit_edge(1'b1, 1'b0, -1);
    endtask

    task automatic tail(input int rdy_k);
        bit_edge(1'b0, pend, rdy_k);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        bclk = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        clear_overrun = 1'b0;
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        en = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (m_left !== 24'h0) begin fails++; $display("FAIL reset_left got %h exp 0", m_left); end
        tests++; if (m_right !== 24'h0) begin fails++; $display("FAIL reset_right got %h exp 0", m_right); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", m_valid); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_basic();
        int h0;
        do_reset();
        m_ready = 1'b1;
        h0 = hs_total;
        preamble();
        send_frame(32'h12345600, 32'hABCDEF00, 32);
        tail(-1);
        tests++; if (mv_hist[3] !== 1'b0) begin fails++; $display("FAIL lat_early got %b exp 0", mv_hist[3]); end
        tests++; if (mv_hist[4] !== 1'b1) begin fails++; $display("FAIL lat_exact got %b exp 1", mv_hist[4]); end
        tests++; if (mv_hist[5] !== 1'b0) begin fails++; $display("FAIL lat_pulse got %b exp 0", mv_hist[5]); end
        tests++; if (hs_total - h0 !== 1) begin fails++; $display("FAIL basic_count got %0d exp 1", hs_total - h0); end
        tests++; if (hs_left !== 24'h123456) begin fails++; $display("FAIL basic_left got %h exp 123456", hs_left); end
        tests++; if (hs_right !== 24'hABCDEF) begin fails++; $display("FAIL basic_right got %h exp abcdef", hs_right); end
    endtask

    task automatic test_short_slot();
        int h0;
        do_reset();
        m_ready = 1'b1;
        h0 = hs_total;
        preamble();
        send_frame(32'h0000BEEF, 32'h00000001, 16);
        tail(-1);
        tests++; if (hs_total - h0 !== 1) begin fails++; $display("FAIL short_count got %0d exp 1", hs_total - h0); end
        tests++; if (hs_left !== 24'hBEEF00) begin fails++; $display("FAIL short_left got %h exp beef00", hs_left); end
        tests++; if (hs_right !== 24'h000100) begin fails++; $display("FAIL short_right got %h exp 000100", hs_right); end
    endtask

    task automatic test_overrun();
        do_reset();
        m_ready = 1'b0;
        preamble();
        send_frame(32'h00111111, 32'h00222222, 24);
        send_frame(32'h00333333, 32'h00444444, 24);
        tail(-1);
        tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b exp 1", m_valid); end
        tests++; if (m_left !== 24'h111111) begin fails++; $display("FAIL ovr_left got %h exp 111111", m_left); end
        tests++; if (m_right !== 24'h222222) begin fails++; $display("FAIL ovr_right got %h exp 222222", m_right); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_set got %b exp 1", overrun); end
        clear_overrun = 1'b1;
        @(negedge aclk);
        clear_overrun = 1'b0;
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b exp 0", overrun); end
        m_ready = 1'b1;
        @(negedge aclk);
        m_ready = 1'b0;
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL ovr_drain got %b exp 0", m_valid); end
        tests++; if (m_left !== 24'h111111) begin fails++; $display("FAIL ovr_hold got %h exp 111111", m_left); end
    endtask

    task automatic test_back_to_back();
        int h0;
        do_reset();
        m_ready = 1'b0;
        preamble();
        send_frame(32'h005A5A5A, 32'h00A5A5A5, 24);
        send_frame(32'h000C0FFE, 32'h00123ABC, 24);
        h0 = hs_total;
        tail(3);
        tests++; if (mv_hist[3] !== 1'b1) begin fails++; $display("FAIL b2b_prev got %b exp 1", mv_hist[3]); end
        tests++; if (mv_hist[5] !== 1'b1) begin fails++; $display("FAIL b2b_stay got %b exp 1", mv_hist[5]); end
        tests++; if (hs_left !== 24'h5A5A5A) begin fails++; $display("FAIL b2b_taken got %h exp 5a5a5a", hs_left); end
        tests++; if (hs_total - h0 !== 1) begin fails++; $display("FAIL b2b_count got %0d exp 1", hs_total - h0); end
        tests++; if (m_left !== 24'h0C0FFE) begin fails++; $display("FAIL b2b_left got %h exp 0c0ffe", m_left); end
        tests++; if (m_right !== 24'h123ABC) begin fails++; $display("FAIL b2b_right got %h exp 123abc", m_right); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    endtask

    // mode 0: break with en, mode 1: break with ARESET
    task automatic test_break(input int mode);
        int h0;
        do_reset();
        m_ready = 1'b1;
        h0 = hs_total;
        preamble();
        for (int i = 0; i < 10; i++) bit_edge(1'b0, 1'b1, -1);
        if (mode == 0) en = 1'b0;
        else areset = 1'b1;
        repeat (5) @(negedge aclk);
        en = 1'b1;
        areset = 1'b0;
        for (int i = 0; i < 22; i++) bit_edge(1'b0, 1'b1, -1);
        for (int i = 0; i < 32; i++) bit_edge(1'b1, 1'b1, -1);
        pend = 1'b1;
        send_frame(32'h0A0B0C00, 32'h0D0E0F00, 32);
        tail(-1);
        tests++; if (hs_total - h0 !== 1) begin fails++; $display("FAIL break%0d_count got %0d exp 1", mode, hs_total - h0); end
        tests++; if (hs_left !== 24'h0A0B0C) begin fails++; $display("FAIL break%0d_left got %h exp 0a0b0c", mode, hs_left); end
        tests++; if (hs_right !== 24'h0D0E0F) begin fails++; $display("FAIL break%0d_right got %h exp 0d0e0f", mode, hs_right); end
    endtask

    task automatic test_lj();
        logic [W-1:0] exp_l;
        logic [W-1:0] exp_r;
`ifdef I2S_RX_LJ_EN
        exp_l = 24'h800001;
        exp_r = 24'h7FFFFF;
`else
        exp_l = 24'h000002;
        exp_r = 24'hFFFFFE;
`endif
        do_reset();
        m_ready = 1'b1;
        preamble();
        send_word_lj(1'b0, 32'h80000100, 32);
        send_word_lj(1'b1, 32'h7FFFFF00, 32);
        tail(-1);
        tests++; if (hs_left !== exp_l) begin fails++; $display("FAIL lj_left got %h exp %h", hs_left, exp_l); end
        tests++; if (hs_right !== exp_r) begin fails++; $display("FAIL lj_right got %h exp %h", hs_right, exp_r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_slot();
        test_overrun();
        test_back_to_back();
        test_break(0);
        test_break(1);
        test_lj();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
